// File: rtl/vga_pixel_fetch_if.sv
// Memory read port between the pixel fetcher and the framebuffer.
// The request is single-outstanding. mem_addr stays stable while mem_req is high.
// mem_rdata is valid in the cycle where mem_ack is high.
interface vga_pixel_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Framebuffer prefetcher for the VGA pixel path.
// It streams 32-bit pixels from memory into a show-ahead FIFO.
// The FIFO head is popped on every pixel clock that is inside the display area.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | idle with frame data still to read; raise mem_req when there is room
// S_WAIT  | one read outstanding; on ack push the data, then continue or back off
// S_DONE  | whole frame fetched; idle until the next frame restart
// S_FLUSH | restart arrived mid-read; wait for that ack, then drop the data
module vga_pixel_fetch #(
   parameter int unsigned RES_X           = 640,
   parameter int unsigned RES_Y           = 480,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   parameter int unsigned FIFO_DEPTH      = 16,
   parameter logic [31:0] UNDERFLOW_COLOR = 32'h00FF00FF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [9:0]                    COL,
   input  logic [8:0]                    LINE,
   input  logic                          inDisplayArea,
   vga_pixel_fetch_if.master             mem,
   output logic [31:0]                   pixel,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          underflow
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned NPIX = RES_X * RES_Y;
   localparam int unsigned CW   = $clog2(NPIX);
   localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DONE,
      S_FLUSH
   } state_t;

   state_t        state, state_n;
   logic          req_q, req_n;
   logic [31:0]   addr_q, addr_n;
   logic [CW-1:0] cnt_q, cnt_n;

   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_after;
   logic          restart, push, pop, room_more;

   // The first line of vertical blanking marks the start of a new frame.
   assign restart = (LINE == 9'(RES_Y)) && (COL == 10'd0);

   // On a restart the returned data is never pushed. If the ack lands on the
   // restart cycle itself, that data is simply dropped.
   assign push        = (state == S_WAIT) && mem.mem_ack && !restart;
   assign pop         = inDisplayArea && (level != '0);
   assign level_after = level + LW'(push) - LW'(pop);
   assign room_more   = level_after < DEPTH_L;

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;
   assign pixel        = (level == '0) ? UNDERFLOW_COLOR : fifo_mem[rd_ptr];

   // FSM state and memory-request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_FETCH;
         req_q  <= 1'b0;
         addr_q <= BASE_ADDR;
         cnt_q  <= '0;
      end else begin
         state  <= state_n;
         req_q  <= req_n;
         addr_q <= addr_n;
         cnt_q  <= cnt_n;
      end
   end

   // Next state and request control. The outstanding read is counted against
   // the room in the FIFO, so a push can never overflow it.
   always_comb begin
      state_n = state;
      req_n   = req_q;
      addr_n  = addr_q;
      cnt_n   = cnt_q;
      case (state)
         S_FETCH: begin
            if (restart) begin
               cnt_n  = '0;
               addr_n = BASE_ADDR;
            end else if (level < DEPTH_L) begin
               req_n   = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (restart) begin
               if (mem.mem_ack) begin
                  req_n   = 1'b0;
                  cnt_n   = '0;
                  addr_n  = BASE_ADDR;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_FLUSH;
               end
            end else if (mem.mem_ack) begin
               if (cnt_q == LAST_PIX) begin
                  req_n   = 1'b0;
                  state_n = S_DONE;
               end else begin
                  cnt_n  = cnt_q + 1'b1;
                  addr_n = addr_q + 32'd4;
                  if (!room_more) begin
                     req_n   = 1'b0;
                     state_n = S_FETCH;
                  end
               end
            end
         end
         S_DONE: begin
            if (restart) begin
               cnt_n   = '0;
               addr_n  = BASE_ADDR;
               state_n = S_FETCH;
            end
         end
         S_FLUSH: begin
            if (mem.mem_ack) begin
               req_n   = 1'b0;
               cnt_n   = '0;
               addr_n  = BASE_ADDR;
               state_n = S_FETCH;
            end
         end
         default: state_n = S_FETCH;
      endcase
   end

   // FIFO pointers and occupancy. A restart empties the FIFO at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (restart) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level_after;
      end
   end

   // FIFO storage write (no reset needed; contents are qualified by level)
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem.mem_rdata;
   end

   // Sticky underflow flag: the consumer sampled while the FIFO was empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  underflow <= 1'b0;
      else if (inDisplayArea && level == '0)    underflow <= 1'b1;
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch with an 8x4 frame and a 4-deep FIFO.
// The memory model returns rdata = addr >> 2. Its ack comes ack_dly clocks
// after the request rises.
module tb_vga_pixel_fetch;
   localparam logic [31:0] UCOL = 32'h00FF00FF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] col = '0;
   logic [8:0] line_ = '0;
   logic       disp = 1'b0;
   logic [31:0] pixel;
   logic [2:0]  level;
   logic        underflow;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_dly = 0;
   int wait_cnt = 0;
   int ack_cnt = 0;
   logic [31:0] last_addr = '0;

   vga_pixel_fetch_if bus ();

   vga_pixel_fetch #(
      .RES_X(8), .RES_Y(4), .BASE_ADDR(32'h0), .FIFO_DEPTH(4), .UNDERFLOW_COLOR(UCOL)
   ) dut (
      .clk(clk), .rst(rst), .COL(col), .LINE(line_), .inDisplayArea(disp),
      .mem(bus), .pixel(pixel), .level(level), .underflow(underflow)
   );

   always #5 clk = ~clk;

   assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_dly);
   assign bus.mem_rdata = bus.mem_addr >> 2;

   always @(posedge clk) begin
      if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
      else                             wait_cnt <= wait_cnt + 1;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_cnt   <= 0;
         last_addr <= '0;
      end else if (bus.mem_req && bus.mem_ack) begin
         ack_cnt   <= ack_cnt + 1;
         last_addr <= bus.mem_addr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic pulse_restart();
      line_ = 9'd4;
      col   = 10'd0;
      tick();
      line_ = 9'd0;
      col   = 10'd1;
   endtask

   initial begin
      int n;
      int exp_pix;

      // 1: reset values, then reset asserted in the middle of a read
      ack_dly = 5;
      repeat (3) tick();
      chk("t1_req", 32'(bus.mem_req), 0);
      chk("t1_addr", bus.mem_addr, 0);
      chk("t1_level", 32'(level), 0);
      chk("t1_uflow", 32'(underflow), 0);
      chk("t1_pixel", pixel, UCOL);
      rst = 1'b0;
      tick();
      chk("t1_in_wait", 32'(bus.mem_req), 1);
      tick();
      rst = 1'b1;
      #1;
      chk("t1_mid_req", 32'(bus.mem_req), 0);
      chk("t1_mid_addr", bus.mem_addr, 0);
      chk("t1_mid_level", 32'(level), 0);
      chk("t1_mid_pixel", pixel, UCOL);

      // 2: zero-wait slave fills the FIFO with four back-to-back reads
      ack_dly = 0;
      disp = 1'b0;
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_req%0d", i), 32'(bus.mem_req), 1);
         chk($sformatf("t2_addr%0d", i), bus.mem_addr, 32'(4 * i));
         tick();
      end
      chk("t2_full_level", 32'(level), 4);
      chk("t2_full_req", 32'(bus.mem_req), 0);
      tick();
      chk("t2_idle_req", 32'(bus.mem_req), 0);

      // 3: drain 8 pixels while refilling
      disp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3_pix%0d", i), pixel, 32'(i));
         chk($sformatf("t3_lvl%0d", i), 32'(level <= 3'd4), 1);
         tick();
      end
      chk("t3_req", 32'(bus.mem_req), 1);
      chk("t3_uflow", 32'(underflow), 0);

      // 4: slow slave, continuous pop -> sticky underflow
      disp = 1'b0;
      ack_dly = 3;
      rst = 1'b1;
      repeat (3) tick();
      disp = 1'b1;
      rst = 1'b0;
      chk("t4_empty_pixel", pixel, UCOL);
      chk("t4_empty_level", 32'(level), 0);
      tick();
      chk("t4_uflow_set", 32'(underflow), 1);
      repeat (100) tick();
      chk("t4_uflow_sticky", 32'(underflow), 1);

      // 5: restart while a read is pending with a 5-clock ack
      disp = 1'b0;
      ack_dly = 5;
      do_reset();
      n = 0;
      while (level != 3'd2 && n < 40) begin tick(); n++; end
      chk("t5_reach_lvl2", 32'(n < 40), 1);
      chk("t5_pending_addr", bus.mem_addr, 8);
      pulse_restart();
      chk("t5_flush_level", 32'(level), 0);
      chk("t5_flush_req", 32'(bus.mem_req), 1);
      chk("t5_flush_addr", bus.mem_addr, 8);
      n = 0;
      while (bus.mem_req && n < 20) begin
         if (bus.mem_addr != 32'd8) chk("t5_addr_held", bus.mem_addr, 8);
         tick();
         n++;
      end
      chk("t5_ack_seen", 32'(n < 20), 1);
      chk("t5_discard_level", 32'(level), 0);
      chk("t5_rewind_addr", bus.mem_addr, 0);
      tick();
      chk("t5_next_req", 32'(bus.mem_req), 1);
      chk("t5_next_addr", bus.mem_addr, 0);
      n = 0;
      while (level == 3'd0 && n < 20) begin tick(); n++; end
      chk("t5_first_pixel", pixel, 0);

      // 6: fast slave fetches the whole frame, then idles until restart
      ack_dly = 0;
      disp = 1'b0;
      do_reset();
      disp = 1'b1;
      exp_pix = 0;
      for (int i = 0; i < 80; i++) begin
         if (level != 3'd0) begin
            chk($sformatf("t6_pix%0d", exp_pix), pixel, 32'(exp_pix));
            exp_pix++;
         end
         tick();
      end
      chk("t6_pop_count", 32'(exp_pix), 32);
      chk("t6_ack_count", 32'(ack_cnt), 32);
      chk("t6_last_addr", last_addr, 124);
      chk("t6_done_req", 32'(bus.mem_req), 0);
      disp = 1'b0;
      repeat (10) tick();
      chk("t6_done_idle", 32'(bus.mem_req), 0);
      pulse_restart();
      chk("t6_rst_addr", bus.mem_addr, 0);
      chk("t6_rst_level", 32'(level), 0);
      tick();
      chk("t6_restart_req", 32'(bus.mem_req), 1);
      chk("t6_restart_addr", bus.mem_addr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
